// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, IF/ID payload
// and the reserved instruction encodings.
package cpu_pkg;

  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_WORD, pc4: 32'h0, valid: 1'b0};

  // Branch/jump targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble beats load; neither asserted means hold.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (reset || bubble) q <= IFID_BUBBLE;
    else if (load)       q <= d;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, fetch/drain/halt FSM and the IF/ID register.
// imem_addr comes straight from the PC flop, so no input reaches an output combinationally.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
  parameter logic [31:0] HALT_WORD    = DEF_HALT_WORD,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [15:0] if_id_imm,
  output logic        if_id_valid,
  output logic        halted
);

  localparam logic [2:0] CNT_LAST = 3'(DRAIN_CYCLES - 1);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_plus4;
  logic [2:0]   cnt;
  logic         is_halt;
  logic         pc_load, ifid_load, ifid_bubble, cnt_clr, cnt_inc;
  ifid_t        ifid_d, ifid_q;

  assign pc_plus4 = pc + 32'd4;
  assign is_halt  = (imem_data == HALT_WORD);

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (redirect_valid)         state_nxt = FETCH;
        else if (!stall && is_halt) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (redirect_valid)         state_nxt = FETCH;
        else if (cnt == CNT_LAST)   state_nxt = HALTED;
      end
      HALTED:                       state_nxt = HALTED;
      default:                      state_nxt = FETCH;
    endcase
  end

  // Per-state datapath controls; redirect outranks stall, and the halt word
  // itself is latched into IF/ID so ID can see it while the PC freezes.
  always_comb begin
    pc_load     = 1'b0;
    pc_nxt      = pc;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      FETCH: begin
        if (redirect_valid) begin
          pc_load     = 1'b1;
          pc_nxt      = align_word(redirect_pc);
          ifid_bubble = 1'b1;
          cnt_clr     = 1'b1;
        end else if (!stall) begin
          ifid_load = 1'b1;
          if (is_halt) begin
            cnt_clr = 1'b1;
          end else begin
            pc_load = 1'b1;
            pc_nxt  = pc_plus4;
          end
        end
      end
      DRAIN: begin
        ifid_bubble = 1'b1;
        if (redirect_valid) begin
          pc_load = 1'b1;
          pc_nxt  = align_word(redirect_pc);
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)        pc <= RESET_PC;
    else if (pc_load) pc <= pc_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) cnt <= 3'd0;
    else if (cnt_inc)     cnt <= cnt + 3'd1;
  end

  assign ifid_d = '{instr: imem_data, pc4: pc_plus4, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign imem_addr   = pc;
  assign if_id_instr = ifid_q.instr;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_imm   = ifid_q.instr[15:0];
  assign if_id_valid = ifid_q.valid;
  assign halted      = (state == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a cycle-level behavioural model predicts the
// outputs after every edge; a negedge monitor pops and compares.
module tb_if_stage;

  localparam int DRAIN = 4;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [15:0] if_id_imm;
  logic        if_id_valid;
  logic        halted;

  if_stage #(.RESET_PC(32'h0), .HALT_WORD(32'hFFFF_FFFF), .DRAIN_CYCLES(DRAIN)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .if_id_imm      (if_id_imm),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: fixed word at 0, halt words at 0x10 and 0x1F0, hash elsewhere.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h10 || a == 32'h1F0) return 32'hFFFF_FFFF;
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (h == 32'hFFFF_FFFF) h = 32'h0;
    return h;
  endfunction

  assign imem_data = word_at(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Model: age counts edges since the halt word was latched; -1 means not halting.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc4 = 32'h0;
  logic        m_valid = 1'b0;
  int          m_age = -1;

  task automatic model_edge(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    logic [31:0] w;
    if (r) begin
      m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_age = -1;
    end else if (m_age >= DRAIN) begin
      // halted: everything frozen
    end else if (rv) begin
      m_pc = rp & ~32'h3; m_instr = 0; m_pc4 = 0; m_valid = 0; m_age = -1;
    end else if (m_age >= 0) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_age = m_age + 1;
    end else if (!s) begin
      w = word_at(m_pc);
      m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      if (w == 32'hFFFF_FFFF) m_age = 0;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    exp_t e;
    @(negedge clk);
    reset = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    @(posedge clk);
    model_edge(r, s, rv, rp);
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.halted = (m_age >= DRAIN);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL cycle %0d %s: got %h expected %h", cyc, name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("imem_addr", imem_addr, e.pc);
      check("if_id_instr", if_id_instr, e.instr);
      check("if_id_pc4", if_id_pc4, e.pc4);
      check("if_id_imm", {16'h0, if_id_imm}, {16'h0, e.instr[15:0]});
      check("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
      check("halted", {31'h0, halted}, {31'h0, e.halted});
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset, first fetch, 3-cycle stall at 0x8, then run into the halt word at 0x10.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h200); step(0, 1, 0, 0); step(0, 0, 0, 0);

    // Redirect together with stall to an unaligned target.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0043);
    repeat (3) step(0, 0, 0, 0);

    // Halt then redirect during the second drain cycle; stall ignored in drain.
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 32'h100);
    repeat (6) step(0, 0, 0, 0);

    // PC wrap at the top of memory, then halt and reset out of HALTED.
    step(0, 0, 1, 32'hFFFF_FFF8);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h10);
    repeat (8) step(0, 0, 0, 0);
    step(1, 1, 1, 32'h40);
    repeat (2) step(0, 0, 0, 0);

    // Random traffic over a small address window that contains both halt words.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 19) == 0);
      rp = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
      step(r, s, rv, rp);
    end

    @(negedge clk); @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
